// File: rtl/taxi_pkg.sv
// Shared definitions for the taxi meter trip sequencer: state codes,
// tariff width and the unit-price sanitising helper.
package taxi_pkg;

  localparam int TARIFF_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_BILL   = 3'd4
  } state_t;

  localparam logic [TARIFF_W-1:0] PERCOST_MIN = 3'd1;

  // A zero unit price would make the meter free; force it to the minimum.
  function automatic logic [TARIFF_W-1:0] fix_percost(input logic [TARIFF_W-1:0] p);
    if (p == 3'd0) begin
      fix_percost = PERCOST_MIN;
    end else begin
      fix_percost = p;
    end
  endfunction

endpackage

// File: rtl/taxi_trip_ctrl_btn_edge.sv
// Push-button rising-edge detector: one registered history bit per button,
// so a held button produces exactly one event.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_btn_q;

  // Remember last cycle's button level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= i_btn;
    end
  end

  assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Taxi meter trip sequencer: trip FSM, latched tariff, run/wait second
// timers and the strobes that drive the meter datapath.
module taxi_trip_ctrl
  import taxi_pkg::*;
#(
  parameter int                  WAIT_UNIT   = 5,
  parameter int                  BILL_HOLD_S = 10,
  parameter int                  TW          = 16,
  parameter logic [TARIFF_W-1:0] DEF_INIT    = 3'd5,
  parameter logic [TARIFF_W-1:0] DEF_PER     = 3'd2,
  parameter logic [TARIFF_W-1:0] DEF_MAIL    = 3'd3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick_1hz,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_finish,
  input  logic                i_cfg,
  input  logic [TARIFF_W-1:0] i_initcost_in,
  input  logic [TARIFF_W-1:0] i_percost_in,
  input  logic [TARIFF_W-1:0] i_addmail_in,
  output logic [2:0]          o_state,
  output logic                o_meter_run,
  output logic                o_meter_clr,
  output logic                o_cfg_load,
  output logic [TARIFF_W-1:0] o_initcost,
  output logic [TARIFF_W-1:0] o_percost,
  output logic [TARIFF_W-1:0] o_addmail,
  output logic                o_wait_chg,
  output logic [TW-1:0]       o_trip_sec,
  output logic [TW-1:0]       o_wait_sec
);

  localparam int SW = $clog2(WAIT_UNIT + 1);
  localparam int HW = $clog2(BILL_HOLD_S + 1);

  localparam logic [TW-1:0] SEC_MAX   = '1;
  localparam logic [TW-1:0] SEC_ONE   = TW'(1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(WAIT_UNIT - 1);
  localparam logic [SW-1:0] SUB_ONE   = SW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BILL_HOLD_S - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic w_rise_start, w_rise_pause, w_rise_finish, w_rise_cfg;
  logic w_ev_start, w_ev_pause, w_ev_finish, w_ev_cfg;

  state_t              r_state;
  logic                r_meter_run, r_meter_clr, r_cfg_load, r_wait_chg;
  logic [TARIFF_W-1:0] r_initcost, r_percost, r_addmail;
  logic [TW-1:0]       r_trip_sec, r_wait_sec;
  logic [SW-1:0]       r_sub;
  logic [HW-1:0]       r_hold;

  btn_edge u_edge_start  (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_start),  .o_rise(w_rise_start));
  btn_edge u_edge_pause  (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_pause),  .o_rise(w_rise_pause));
  btn_edge u_edge_finish (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_finish), .o_rise(w_rise_finish));
  btn_edge u_edge_cfg    (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_cfg),    .o_rise(w_rise_cfg));

  // Only the highest-priority event of a cycle survives: finish > pause > start > cfg.
  always_comb begin
    w_ev_finish = w_rise_finish;
    w_ev_pause  = w_rise_pause & ~w_rise_finish;
    w_ev_start  = w_rise_start & ~w_rise_pause & ~w_rise_finish;
    w_ev_cfg    = w_rise_cfg & ~w_rise_start & ~w_rise_pause & ~w_rise_finish;
  end

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    if (v == SEC_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + SEC_ONE;
    end
  endfunction

  // Trip FSM together with tariff latch, second timers and datapath strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_meter_run <= 1'b0;
      r_meter_clr <= 1'b0;
      r_cfg_load  <= 1'b0;
      r_wait_chg  <= 1'b0;
      r_initcost  <= DEF_INIT;
      r_percost   <= DEF_PER;
      r_addmail   <= DEF_MAIL;
      r_trip_sec  <= '0;
      r_wait_sec  <= '0;
      r_sub       <= '0;
      r_hold      <= '0;
    end else begin
      r_meter_clr <= 1'b0;
      r_cfg_load  <= 1'b0;
      r_wait_chg  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_meter_run <= 1'b0;
          if (w_ev_start) begin
            r_state     <= ST_RUN;
            r_meter_run <= 1'b1;
            r_meter_clr <= 1'b1;
            r_trip_sec  <= '0;
            r_wait_sec  <= '0;
            r_sub       <= '0;
          end else if (w_ev_cfg) begin
            r_state <= ST_CONFIG;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CONFIG: begin
          r_meter_run <= 1'b0;
          if (w_ev_finish) begin
            r_state <= ST_IDLE;
          end else if (w_ev_start || w_ev_cfg) begin
            r_state    <= ST_IDLE;
            r_initcost <= i_initcost_in;
            r_percost  <= fix_percost(i_percost_in);
            r_addmail  <= i_addmail_in;
            r_cfg_load <= 1'b1;
          end else begin
            r_state <= ST_CONFIG;
          end
        end
        ST_RUN: begin
          // A tick coinciding with a transition still belongs to RUN.
          if (i_tick_1hz) begin
            r_trip_sec <= sat_inc(r_trip_sec);
          end
          if (w_ev_finish) begin
            r_state     <= ST_BILL;
            r_meter_run <= 1'b0;
            r_hold      <= '0;
          end else if (w_ev_pause) begin
            r_state     <= ST_PAUSE;
            r_meter_run <= 1'b0;
          end else begin
            r_state     <= ST_RUN;
            r_meter_run <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (i_tick_1hz) begin
            r_trip_sec <= sat_inc(r_trip_sec);
            r_wait_sec <= sat_inc(r_wait_sec);
            if (r_sub == SUB_LAST) begin
              r_sub      <= '0;
              r_wait_chg <= 1'b1;
            end else begin
              r_sub <= r_sub + SUB_ONE;
            end
          end
          if (w_ev_finish) begin
            r_state     <= ST_BILL;
            r_meter_run <= 1'b0;
            r_hold      <= '0;
          end else if (w_ev_pause || w_ev_start) begin
            r_state     <= ST_RUN;
            r_meter_run <= 1'b1;
          end else begin
            r_state     <= ST_PAUSE;
            r_meter_run <= 1'b0;
          end
        end
        ST_BILL: begin
          r_meter_run <= 1'b0;
          if (w_ev_finish) begin
            r_state <= ST_IDLE;
          end else if (w_ev_start) begin
            r_state     <= ST_RUN;
            r_meter_run <= 1'b1;
            r_meter_clr <= 1'b1;
            r_trip_sec  <= '0;
            r_wait_sec  <= '0;
            r_sub       <= '0;
          end else if (i_tick_1hz) begin
            if (r_hold == HOLD_LAST) begin
              r_state <= ST_IDLE;
              r_hold  <= '0;
            end else begin
              r_state <= ST_BILL;
              r_hold  <= r_hold + HOLD_ONE;
            end
          end else begin
            r_state <= ST_BILL;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_meter_run <= 1'b0;
        end
      endcase
    end
  end

  assign o_state     = r_state;
  assign o_meter_run = r_meter_run;
  assign o_meter_clr = r_meter_clr;
  assign o_cfg_load  = r_cfg_load;
  assign o_initcost  = r_initcost;
  assign o_percost   = r_percost;
  assign o_addmail   = r_addmail;
  assign o_wait_chg  = r_wait_chg;
  assign o_trip_sec  = r_trip_sec;
  assign o_wait_sec  = r_wait_sec;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Directed self-checking bench for taxi_trip_ctrl (default build plus a
// narrow TW=4 build sharing the same stimulus for saturation).
module tb_taxi_trip_ctrl;

  localparam int B_START  = 0;
  localparam int B_PAUSE  = 1;
  localparam int B_FINISH = 2;
  localparam int B_CFG    = 3;

  logic       clk, rst, tick, start, pause, finish, cfg;
  logic [2:0] initcost_in, percost_in, addmail_in;

  logic [2:0]  state, state4;
  logic        run, clr, load, wchg, run4, clr4, load4, wchg4;
  logic [2:0]  initcost, percost, addmail, initcost4, percost4, addmail4;
  logic [15:0] trip, waits;
  logic [3:0]  trip4, waits4;

  int n_chk = 0;
  int n_err = 0;
  int n_clr = 0;
  int n_wchg = 0;
  int n_load = 0;
  int snap;

  taxi_trip_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_tick_1hz(tick), .i_start(start), .i_pause(pause),
    .i_finish(finish), .i_cfg(cfg), .i_initcost_in(initcost_in), .i_percost_in(percost_in),
    .i_addmail_in(addmail_in), .o_state(state), .o_meter_run(run), .o_meter_clr(clr),
    .o_cfg_load(load), .o_initcost(initcost), .o_percost(percost), .o_addmail(addmail),
    .o_wait_chg(wchg), .o_trip_sec(trip), .o_wait_sec(waits)
  );

  taxi_trip_ctrl #(.TW(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_tick_1hz(tick), .i_start(start), .i_pause(pause),
    .i_finish(finish), .i_cfg(cfg), .i_initcost_in(initcost_in), .i_percost_in(percost_in),
    .i_addmail_in(addmail_in), .o_state(state4), .o_meter_run(run4), .o_meter_clr(clr4),
    .o_cfg_load(load4), .o_initcost(initcost4), .o_percost(percost4), .o_addmail(addmail4),
    .o_wait_chg(wchg4), .o_trip_sec(trip4), .o_wait_sec(waits4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count cycles in which each one-cycle strobe is high.
  always @(posedge clk) begin
    if (clr)  n_clr  <= n_clr + 1;
    if (wchg) n_wchg <= n_wchg + 1;
    if (load) n_load <= n_load + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_START:  start  = v;
      B_PAUSE:  pause  = v;
      B_FINISH: finish = v;
      default:  cfg    = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(1);
    set_btn(b, 1'b0);
    cyc(1);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; finish = 1'b0; cfg = 1'b0;
    initcost_in = 3'd0; percost_in = 3'd0; addmail_in = 3'd0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_run", run, 0);
    chk("rst_clr", clr, 0);
    chk("rst_load", load, 0);
    chk("rst_wchg", wchg, 0);
    chk("rst_trip", trip, 0);
    chk("rst_wait", waits, 0);
    chk("rst_tariff", {initcost, percost, addmail}, {3'd5, 3'd2, 3'd3});
    rst = 1'b0;
    cyc(1);

    // Tariff configuration, zero unit price becomes 1.
    cfg = 1'b1; cyc(1); cfg = 1'b0;
    chk("cfg_enter", state, 1);
    initcost_in = 3'd6; percost_in = 3'd0; addmail_in = 3'd4;
    cyc(1);
    chk("cfg_nolatch", initcost, 5);
    snap = n_load;
    cfg = 1'b1; cyc(1); cfg = 1'b0;
    chk("cfg_exit_state", state, 0);
    chk("cfg_load_hi", load, 1);
    chk("cfg_tariff", {initcost, percost, addmail}, {3'd6, 3'd1, 3'd4});
    cyc(2);
    chk("cfg_load_once", n_load - snap, 1);

    // Run 3 s, pause 12 s, resume.
    snap = n_clr;
    start = 1'b1; cyc(1); start = 1'b0;
    chk("run_state", state, 2);
    chk("run_clr", clr, 1);
    chk("run_meter", run, 1);
    chk("run_trip0", trip, 0);
    cyc(1);
    chk("run_clr_lo", clr, 0);
    repeat (3) do_tick();
    chk("run_trip3", trip, 3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("pause_state", state, 3);
    chk("pause_meter", run, 0);
    begin
      int w0;
      w0 = n_wchg;
      for (int k = 1; k <= 12; k++) begin
        tick = 1'b1; cyc(1); tick = 1'b0;
        chk($sformatf("wchg_t%0d", k), wchg, ((k % 5) == 0) ? 1 : 0);
        cyc(1);
      end
      chk("wchg_count", n_wchg - w0, 2);
    end
    chk("pause_wait12", waits, 12);
    chk("pause_trip15", trip, 15);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("resume_state", state, 2);
    chk("resume_noclr", clr, 0);
    chk("resume_meter", run, 1);
    cyc(1);
    chk("clr_once", n_clr - snap, 1);

    // pause and finish together in RUN: finish wins.
    pause = 1'b1; finish = 1'b1; cyc(1); pause = 1'b0; finish = 1'b0;
    chk("pf_state", state, 4);
    chk("pf_meter", run, 0);
    cyc(1);
    chk("pf_state2", state, 4);

    // BILL holds for 10 ticks.
    for (int k = 1; k <= 10; k++) begin
      do_tick();
      if (k == 9) begin
        chk("bill_hold9", state, 4);
        chk("bill_trip_frozen", trip, 15);
      end
      if (k == 10) chk("bill_exit10", state, 0);
    end

    // BILL, 4 ticks, start -> RUN with clear.
    press(B_START);
    do_tick();
    do_tick();
    press(B_FINISH);
    chk("bill2_state", state, 4);
    repeat (4) do_tick();
    start = 1'b1; cyc(1); start = 1'b0;
    chk("bill_start_state", state, 2);
    chk("bill_start_clr", clr, 1);
    chk("bill_start_trip0", trip, 0);
    cyc(1);

    // Hold counter restarts on each BILL entry.
    press(B_FINISH);
    for (int k = 1; k <= 10; k++) begin
      do_tick();
      if (k == 9) chk("bill3_hold9", state, 4);
      if (k == 10) chk("bill3_exit10", state, 0);
    end

    // Held start gives one event.
    snap = n_clr;
    start = 1'b1; cyc(50); start = 1'b0;
    cyc(1);
    chk("hold_start_clr", n_clr - snap, 1);
    chk("hold_start_state", state, 2);

    // Saturation in the narrow build.
    repeat (20) do_tick();
    chk("trip20", trip, 20);
    chk("trip4_sat", trip4, 15);
    press(B_FINISH);
    press(B_FINISH);
    chk("idle_again", state, 0);

    // Reset mid-RUN.
    press(B_START);
    repeat (7) do_tick();
    chk("pre_rst_trip7", trip, 7);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_trip", trip, 0);
    chk("midrst_run", run, 0);
    chk("midrst_tariff", {initcost, percost, addmail}, {3'd5, 3'd2, 3'd3});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
